// File: rtl/ecg_pkg.sv
// ecg_pkg: shared types and constants for the ECG sample UART packetizer.
//   SMPL_W        sample width from the MCP3202 sampler
//   FRAME_SYNC    default frame header byte
//   frame_state_e frame FSM states
//   clks_per_bit  system clocks per UART bit, truncated
package ecg_pkg;

    localparam int unsigned SMPL_W     = 12;
    localparam logic [7:0]  FRAME_SYNC = 8'hA5;

    typedef logic [SMPL_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        HI,
        LO
    } frame_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned fclk, input int unsigned baud);
        return fclk / baud;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 UART transmitter (start bit, 8 data bits LSB first, stop bit).
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load din and begin a byte (accepted when idle or on the last stop-bit clock)
//   din         byte to send
//   tx          serial output, idle high
//   done        1-clk pulse during the last clock of the stop bit
module uart_tx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic             busy_q;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shreg;    // remaining data bits plus stop bit
    logic             last_c;
    logic             accept_c;

    // A new byte may be loaded on the final stop-bit clock so bytes abut with no idle time.
    assign last_c   = busy_q && (cnt == CNT_W'(CLKS_PER_BIT - 1)) && (bit_idx == 4'd9);
    assign accept_c = start && (!busy_q || last_c);

    // Baud counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= busy_q && (bit_idx == 4'd9) && (cnt == CNT_W'(CLKS_PER_BIT - 2));
            if (accept_c) begin
                busy_q  <= 1'b1;
                cnt     <= '0;
                bit_idx <= '0;
                shreg   <= {1'b1, din};
                tx      <= 1'b0;
            end else if (busy_q) begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt <= '0;
                    if (bit_idx == 4'd9) begin
                        busy_q <= 1'b0;
                        tx     <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        tx      <= shreg[0];
                        shreg   <= {1'b1, shreg[8:1]};
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ecg_sample_uart_packetizer.sv
// ecg_sample_uart_packetizer: captures 12-bit samples on dv rising edges into a FIFO and
// sends each one over UART 8N1 as the frame {SYNC_BYTE, {4'h0,data[11:8]}, data[7:0]}.
//   clk, rst_n  clock, asynchronous active-low reset (deassertion synchronised internally)
//   data, dv    sample and its valid level from the SPI sampler
//   uart_tx     serial output, idle high
//   busy        frame in progress or FIFO non-empty
//   overflow    sticky, a sample was dropped on a full FIFO
//   fifo_cnt    FIFO occupancy
module ecg_sample_uart_packetizer
    import ecg_pkg::*;
#(
    parameter int unsigned FCLK      = 100_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned FIFO_AW   = 2,
    parameter logic [7:0]  SYNC_BYTE = FRAME_SYNC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SMPL_W-1:0] data,
    input  logic              dv,
    output logic              uart_tx,
    output logic              busy,
    output logic              overflow,
    output logic [FIFO_AW:0]  fifo_cnt
);

    localparam int unsigned CPB   = clks_per_bit(FCLK, BAUD);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;

    logic [1:0]         rst_sync;
    logic               rst_int_n;
    logic               dv_q;
    logic               push_c;
    logic               pop_c;
    logic               full_c;
    logic               empty_c;
    logic               wr_en_c;
    logic               drop_c;
    logic [CNT_W-1:0]   cnt_nx_c;
    sample_t            mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    sample_t            hold;
    frame_state_e       state;
    frame_state_e       state_nx;
    logic               issued;
    logic               issued_nx;
    logic               start_c;
    logic [7:0]         tx_byte_c;
    logic               tx_done;

    function automatic logic [7:0] byte_for(input frame_state_e s, input sample_t h);
        case (s)
            HI:      return {4'h0, h[SMPL_W-1:8]};
            LO:      return h[7:0];
            default: return SYNC_BYTE;
        endcase
    endfunction

    // Reset: asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // dv edge detect: one push per rising edge.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) dv_q <= 1'b0;
        else            dv_q <= dv;
    end
    assign push_c = dv && !dv_q;

    assign full_c  = (fifo_cnt == CNT_W'(DEPTH));
    assign empty_c = (fifo_cnt == '0);
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign wr_en_c = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;

    always_comb begin
        cnt_nx_c = fifo_cnt;
        if (wr_en_c && !pop_c)      cnt_nx_c = fifo_cnt + CNT_W'(1);
        else if (!wr_en_c && pop_c) cnt_nx_c = fifo_cnt - CNT_W'(1);
    end

    // FIFO storage, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr] <= data;
    end

    // FIFO pointers, occupancy, overflow flag and busy.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop_c)   rd_ptr <= rd_ptr + FIFO_AW'(1);
            fifo_cnt <= cnt_nx_c;
            if (drop_c) overflow <= 1'b1;
            busy     <= (state_nx != IDLE) || (cnt_nx_c != '0);
        end
    end

    // Frame FSM state register plus holding register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state  <= IDLE;
            issued <= 1'b0;
            hold   <= '0;
        end else begin
            state  <= state_nx;
            issued <= issued_nx;
            if (pop_c) hold <= mem[rd_ptr];
        end
    end

    // Frame FSM next state. On a done pulse the following byte is started in the same
    // cycle, which the UART accepts on its last stop-bit clock: no gap between bytes.
    always_comb begin
        state_nx  = state;
        issued_nx = issued;
        pop_c     = 1'b0;
        start_c   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    state_nx  = SYNC;
                    issued_nx = 1'b0;
                end
            end
            SYNC, HI, LO: begin
                if (!issued) begin
                    start_c   = 1'b1;
                    issued_nx = 1'b1;
                end else if (tx_done) begin
                    if (state == SYNC) begin
                        state_nx = HI;
                        start_c  = 1'b1;
                    end else if (state == HI) begin
                        state_nx = LO;
                        start_c  = 1'b1;
                    end else if (!empty_c) begin
                        pop_c    = 1'b1;
                        state_nx = SYNC;
                        start_c  = 1'b1;
                    end else begin
                        state_nx  = IDLE;
                        issued_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx  = IDLE;
                issued_nx = 1'b0;
            end
        endcase
    end

    assign tx_byte_c = byte_for(state_nx, hold);

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CPB)
    ) u_uart (
        .clk   (clk),
        .rst_n (rst_int_n),
        .start (start_c),
        .din   (tx_byte_c),
        .tx    (uart_tx),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_ecg_sample_uart_packetizer.sv
// Bench for ecg_sample_uart_packetizer at 16 clocks per bit (100 MHz / 6.25 Mbaud).
module tb_ecg_sample_uart_packetizer;

    localparam int unsigned CPB = 16;
    localparam int unsigned BYTE_CLKS = 10 * CPB;

    logic        clk;
    logic        rst_n;
    logic [11:0] data;
    logic        dv;
    logic        uart_tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ferr  = 0;
    int max_cnt = 0;
    logic [7:0] rx_q[$];
    int         st_q[$];
    logic [7:0] exp_q[$];

    ecg_sample_uart_packetizer #(
        .FCLK     (100_000_000),
        .BAUD     (6_250_000),
        .FIFO_AW  (2),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .dv       (dv),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .overflow (overflow),
        .fifo_cnt (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
        end
    end

    // UART receiver: samples each bit mid-period and logs the byte and its start cycle.
    initial begin
        logic [7:0] rx_b;
        int st;
        forever begin
            @(posedge clk); #1;
            if (rst_n && uart_tx == 1'b0) begin
                st = cyc;
                repeat (CPB / 2) @(posedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(posedge clk); #1;
                    rx_b[b] = uart_tx;
                end
                repeat (CPB) @(posedge clk); #1;
                if (uart_tx !== 1'b1) ferr++;
                rx_q.push_back(rx_b);
                st_q.push_back(st);
                repeat (CPB / 2 - 1) @(posedge clk);
            end
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [11:0] d, input int hi);
        @(posedge clk); #1;
        data = d;
        dv   = 1'b1;
        repeat (hi) @(posedge clk);
        #1 dv = 1'b0;
    endtask

    task automatic expect_sample(input logic [11:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back({4'h0, d[11:8]});
        exp_q.push_back(d[7:0]);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < max_cyc);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        st_q.delete();
        exp_q.delete();
        ferr = 0;
    endtask

    task automatic check_rx(input string tag, input bit gaps);
        int n;
        check_eq({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        if (gaps)
            for (int i = 1; i < st_q.size(); i++)
                check_eq($sformatf("%s_gap%0d", tag, i), 32'(st_q[i] - st_q[i-1]), 32'(BYTE_CLKS));
        check_eq({tag, "_stopbits"}, 32'(ferr), 32'd0);
        clear_rx();
    endtask

    initial begin
        bit seen;
        int lat;
        rst_n = 1'b0;
        dv    = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk); #1;
        check_eq("rst_tx", 32'(uart_tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_cnt", 32'(fifo_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // 1: single sample, latency and exact frame length
        @(posedge clk); #1;
        data = 12'h75F;
        dv   = 1'b1;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 5) dv = 1'b0;
            if (!seen && uart_tx == 1'b0) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check_eq("t1_latency", 32'(lat), 32'd3);
        repeat (3 + 30 * CPB - 1 - 10) @(posedge clk); #1;
        check_eq("t1_busy_last", 32'(busy), 32'd1);
        check_eq("t1_stop_bit", 32'(uart_tx), 32'd1);
        @(posedge clk); #1;
        check_eq("t1_busy_fall", 32'(busy), 32'd0);
        expect_sample(12'h75F);
        check_rx("t1", 1'b1);

        // 2: two samples 10 clk apart, frames abut
        max_cnt = 0;
        send(12'h4E8, 3);
        repeat (6) @(posedge clk);
        send(12'h7FF, 3);
        expect_sample(12'h4E8);
        expect_sample(12'h7FF);
        wait_idle("t2", 2000);
        check_eq("t2_peak_cnt", 32'(max_cnt), 32'd1);
        check_rx("t2", 1'b1);

        // 3: long dv level gives one frame
        send(12'h123, 5000);
        expect_sample(12'h123);
        wait_idle("t3", 2000);
        check_eq("t3_cnt", 32'(fifo_cnt), 32'd0);
        check_rx("t3", 1'b1);

        // 5: ten samples one frame apart, pointers wrap
        for (int k = 1; k <= 10; k++) begin
            send(12'(k), 2);
            expect_sample(12'(k));
            repeat (30 * CPB - 3) @(posedge clk);
        end
        wait_idle("t5", 2000);
        check_eq("t5_ovf", 32'(overflow), 32'd0);
        check_eq("t5_cnt", 32'(fifo_cnt), 32'd0);
        check_rx("t5", 1'b0);

        // 4: six edges 20 clk apart, sixth dropped
        max_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            send(12'h101 + 12'(k), 2);
            if (k < 5) expect_sample(12'h101 + 12'(k));
            repeat (17) @(posedge clk);
        end
        #1;
        check_eq("t4_ovf_set", 32'(overflow), 32'd1);
        check_eq("t4_peak_cnt", 32'(max_cnt), 32'd4);
        wait_idle("t4", 4000);
        check_eq("t4_ovf_sticky", 32'(overflow), 32'd1);
        check_rx("t4", 1'b1);

        // 6: reset during HI byte data bit 3, then a clean frame
        send(12'h3C3, 2);
        repeat (230) @(posedge clk);
        #2;
        check_eq("t6_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_tx", 32'(uart_tx), 32'd1);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_cnt", 32'(fifo_cnt), 32'd0);
        check_eq("t6_rst_ovf", 32'(overflow), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        clear_rx();
        send(12'hABC, 2);
        expect_sample(12'hABC);
        wait_idle("t6", 2000);
        check_rx("t6", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
